// File: rtl/seqframer.sv
// Serial frame transmitter: groups parallel words into frames, prefixes each frame
// with a Sync header and shifts everything out MSB first on a single line.
module seqframer #(
  parameter int unsigned      Width      = 8,
  parameter logic [Width-1:0] Sync       = Width'(8'b00111100),
  parameter int unsigned      FrameBytes = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             sync_active,
  output logic             frame_done,
  output logic             underrun
);

  localparam int unsigned BitCntW  = (Width > 1) ? $clog2(Width) : 1;
  localparam int unsigned WordCntW = 8;

  localparam logic [BitCntW-1:0]  LastBit  = BitCntW'(Width - 1);
  localparam logic [BitCntW-1:0]  PenBit   = BitCntW'(Width - 2);
  localparam logic [WordCntW-1:0] LastWord = WordCntW'(FrameBytes - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_STALL
  } state_t;

  state_t              r_state;
  logic [Width-1:0]    r_hold;
  logic                r_hold_full;
  logic                r_data_ready;
  logic [Width-1:0]    r_shift;
  logic [BitCntW-1:0]  r_bitcnt;
  logic [WordCntW-1:0] r_wordcnt;
  logic                r_dout;
  logic                r_dout_valid;
  logic                r_sync_active;
  logic                r_frame_done;
  logic                r_underrun;

  logic w_accept;
  logic w_last_bit;
  logic w_frame_end;
  logic w_consume;
  logic w_hold_full_nxt;

  assign w_accept    = data_valid && r_data_ready;
  assign w_last_bit  = (r_bitcnt == LastBit);
  assign w_frame_end = (r_wordcnt == LastWord);

  // The shifter takes the held word at these word boundaries; a write can only land
  // when hold is empty, so consume and accept never coincide.
  always_comb begin
    w_consume = 1'b0;
    unique case (r_state)
      S_SYNC:  w_consume = w_last_bit;
      S_DATA:  w_consume = w_last_bit && !w_frame_end && r_hold_full;
      S_STALL: w_consume = r_hold_full;
      default: w_consume = 1'b0;
    endcase
  end

  assign w_hold_full_nxt = w_consume ? 1'b0 : (w_accept ? 1'b1 : r_hold_full);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_hold        <= '0;
      r_hold_full   <= 1'b0;
      r_data_ready  <= 1'b1;
      r_shift       <= '0;
      r_bitcnt      <= '0;
      r_wordcnt     <= '0;
      r_dout        <= 1'b1;
      r_dout_valid  <= 1'b0;
      r_sync_active <= 1'b0;
      r_frame_done  <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_hold <= data_in;
      end
      r_hold_full  <= w_hold_full_nxt;
      r_data_ready <= !w_hold_full_nxt;
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          if (r_hold_full) begin
            r_shift       <= Sync;
            r_dout        <= Sync[Width-1];
            r_bitcnt      <= '0;
            r_dout_valid  <= 1'b1;
            r_sync_active <= 1'b1;
            r_state       <= S_SYNC;
          end else begin
            r_dout        <= 1'b1;
            r_dout_valid  <= 1'b0;
            r_sync_active <= 1'b0;
          end
        end

        S_SYNC: begin
          if (w_last_bit) begin
            r_shift       <= r_hold;
            r_dout        <= r_hold[Width-1];
            r_bitcnt      <= '0;
            r_sync_active <= 1'b0;
            r_state       <= S_DATA;
          end else begin
            r_shift  <= r_shift << 1;
            r_dout   <= r_shift[Width-2];
            r_bitcnt <= r_bitcnt + BitCntW'(1);
          end
        end

        S_DATA: begin
          if (w_last_bit) begin
            if (w_frame_end) begin
              r_wordcnt <= '0;
              if (r_hold_full) begin
                // Next frame is already waiting: header follows with no idle gap.
                r_shift       <= Sync;
                r_dout        <= Sync[Width-1];
                r_bitcnt      <= '0;
                r_sync_active <= 1'b1;
                r_state       <= S_SYNC;
              end else begin
                r_dout        <= 1'b1;
                r_dout_valid  <= 1'b0;
                r_state       <= S_IDLE;
              end
            end else begin
              r_wordcnt <= r_wordcnt + WordCntW'(1);
              if (r_hold_full) begin
                r_shift  <= r_hold;
                r_dout   <= r_hold[Width-1];
                r_bitcnt <= '0;
              end else begin
                r_dout       <= 1'b1;
                r_dout_valid <= 1'b0;
                r_underrun   <= 1'b1;
                r_state      <= S_STALL;
              end
            end
          end else begin
            r_shift      <= r_shift << 1;
            r_dout       <= r_shift[Width-2];
            r_bitcnt     <= r_bitcnt + BitCntW'(1);
            // Registered pulse lines up with the final data bit of the frame.
            r_frame_done <= w_frame_end && (r_bitcnt == PenBit);
          end
        end

        S_STALL: begin
          if (r_hold_full) begin
            r_shift      <= r_hold;
            r_dout       <= r_hold[Width-1];
            r_bitcnt     <= '0;
            r_dout_valid <= 1'b1;
            r_state      <= S_DATA;
          end else begin
            r_dout       <= 1'b1;
            r_dout_valid <= 1'b0;
          end
        end

        default: begin
          r_dout        <= 1'b1;
          r_dout_valid  <= 1'b0;
          r_sync_active <= 1'b0;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

  assign data_ready  = r_data_ready;
  assign dout        = r_dout;
  assign dout_valid  = r_dout_valid;
  assign sync_active = r_sync_active;
  assign frame_done  = r_frame_done;
  assign underrun    = r_underrun;

endmodule

// File: tb/tb_seqframer.sv
// Scoreboard bench for seqframer: expected serial bits are queued at each accepted
// word and checked bit by bit as the line produces them.
module tb_seqframer;

  localparam int W  = 8;
  localparam int FB = 4;
  localparam logic [7:0] SYNC = 8'b00111100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_in = '0;
  logic       data_valid = 1'b0;
  logic       data_ready;
  logic       dout;
  logic       dout_valid;
  logic       sync_active;
  logic       frame_done;
  logic       underrun;

  typedef struct packed {
    logic b;
    logic s;
    logic l;
  } exp_t;

  exp_t expq[$];
  int   flag_pos[$];
  int   tests = 0;
  int   fails = 0;
  int   fpos = 0;
  int   bits_seen = 0;
  int   run_len = 0;
  int   last_run = 0;
  int   gap_len = 0;
  int   last_gap = 0;
  int   urun_cnt = 0;
  int   cyc = 0;
  int   last_accept = 0;
  logic [7:0] det_sr = '0;

  seqframer #(.Width(W), .Sync(SYNC), .FrameBytes(FB)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .sync_active(sync_active),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  initial begin : cycle_counter
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Line monitor: pops the scoreboard on every valid bit, models the detector.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        tests++;
        if (dout_valid === 1'b1) begin
          if (expq.size() == 0) begin
            fails++;
            $display("FAIL unexpected_bit: valid bit %0d with empty scoreboard", bits_seen);
          end else begin
            e = expq.pop_front();
            if ({dout, sync_active, frame_done} !== {e.b, e.s, e.l}) begin
              fails++;
              $display("FAIL bit_stream: bit %0d dout/sync/fdone=%b%b%b required %b%b%b",
                       bits_seen, dout, sync_active, frame_done, e.b, e.s, e.l);
            end
          end
          bits_seen++;
          det_sr = {det_sr[6:0], dout};
          if (det_sr == SYNC) flag_pos.push_back(bits_seen);
          if (gap_len > 0) begin
            last_gap = gap_len;
            gap_len  = 0;
          end
          run_len++;
        end else begin
          if ({dout, dout_valid, sync_active, frame_done} !== 4'b1000) begin
            fails++;
            $display("FAIL idle_line: dout/valid/sync/fdone=%b%b%b%b required 1000",
                     dout, dout_valid, sync_active, frame_done);
          end
          if (run_len > 0) begin
            last_run = run_len;
            run_len  = 0;
          end
          gap_len++;
        end
        if (underrun === 1'b1) urun_cnt++;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push_expected(input logic [7:0] w);
    exp_t e;
    logic [7:0] s;
    s = SYNC;
    if (fpos == 0) begin
      for (int i = W - 1; i >= 0; i--) begin
        e.b = s[i]; e.s = 1'b1; e.l = 1'b0;
        expq.push_back(e);
      end
    end
    for (int i = W - 1; i >= 0; i--) begin
      e.b = w[i]; e.s = 1'b0; e.l = (fpos == FB - 1) && (i == 0);
      expq.push_back(e);
    end
    fpos = (fpos + 1) % FB;
  endtask

  task automatic send_word(input logic [7:0] w);
    int t = 0;
    data_in    = w;
    data_valid = 1'b1;
    while (data_ready !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (data_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: data_ready=%b required 1 within 400 cycles", data_ready);
      data_valid = 1'b0;
      return;
    end
    push_expected(w);
    @(posedge clk);
    @(negedge clk);
    data_valid  = 1'b0;
    last_accept = cyc;
    tests++;
    if (data_ready !== 1'b0) begin
      fails++;
      $display("FAIL ready_after_accept: data_ready=%b required 0", data_ready);
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((expq.size() != 0 || dout_valid === 1'b1) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    tests++;
    if ({dout, dout_valid, sync_active, frame_done, underrun, data_ready} !== 6'b100001) begin
      fails++;
      $display("FAIL reset_values: got %b required 100001",
               {dout, dout_valid, sync_active, frame_done, underrun, data_ready});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests++;
      if ({dout, dout_valid, data_ready} !== 3'b101) begin
        fails++;
        $display("FAIL idle_after_reset: cycle %0d dout/valid/ready=%b required 101",
                 i, {dout, dout_valid, data_ready});
      end
    end
  endtask

  task automatic test_single_frame();
    int base = bits_seen;
    int u0   = urun_cnt;
    det_sr = '0;
    flag_pos.delete();
    send_word(8'hA5);
    send_word(8'h0F);
    send_word(8'hFF);
    send_word(8'h3C);
    drain();
    tests++;
    if (last_run !== 40) begin
      fails++;
      $display("FAIL single_frame_len: %0d contiguous bits required 40", last_run);
    end
    tests++;
    if (flag_pos.size() != 2 || flag_pos[0] != base + 8 || flag_pos[1] != base + 40) begin
      fails++;
      $display("FAIL single_frame_flags: %0d detector flags, required 2 at bits 8 and 40",
               flag_pos.size());
    end
    tests++;
    if (urun_cnt - u0 !== 0 || expq.size() != 0) begin
      fails++;
      $display("FAIL single_frame_tail: underruns=%0d pending=%0d required 0 and 0",
               urun_cnt - u0, expq.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    int base = bits_seen;
    int u0   = urun_cnt;
    det_sr = '0;
    flag_pos.delete();
    for (int i = 0; i < 8; i++) send_word(words[i]);
    drain();
    tests++;
    if (last_run !== 80) begin
      fails++;
      $display("FAIL back_to_back_len: %0d contiguous bits required 80", last_run);
    end
    tests++;
    if (flag_pos.size() != 2 || flag_pos[0] != base + 8 || flag_pos[1] != base + 48) begin
      fails++;
      $display("FAIL back_to_back_flags: %0d detector flags, required 2 at bits 8 and 48",
               flag_pos.size());
    end
    tests++;
    if (urun_cnt - u0 !== 0 || expq.size() != 0) begin
      fails++;
      $display("FAIL back_to_back_tail: underruns=%0d pending=%0d required 0 and 0",
               urun_cnt - u0, expq.size());
    end
  endtask

  task automatic test_underrun();
    int u0 = urun_cnt;
    int t  = 0;
    send_word(8'hC3);
    while (underrun !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    tests++;
    if (underrun !== 1'b1) begin
      fails++;
      $display("FAIL underrun_seen: underrun=%b required 1 at word boundary", underrun);
    end
    repeat (3) @(negedge clk);
    send_word(8'h81);
    send_word(8'h7E);
    send_word(8'hE7);
    repeat (4) @(negedge clk);
    #1;
    tests++;
    if (last_gap !== 5) begin
      fails++;
      $display("FAIL underrun_gap: gap of %0d cycles required 5", last_gap);
    end
    drain();
    tests++;
    if (urun_cnt - u0 !== 1) begin
      fails++;
      $display("FAIL underrun_count: %0d pulse cycles required 1", urun_cnt - u0);
    end
    tests++;
    if (last_run !== 24 || expq.size() != 0) begin
      fails++;
      $display("FAIL underrun_resume: run=%0d pending=%0d required 24 and 0",
               last_run, expq.size());
    end
  endtask

  task automatic test_backpressure();
    int prev = 0;
    int u0   = urun_cnt;
    for (int i = 0; i < 12; i++) begin
      send_word(8'($urandom));
      if (i >= 2) begin
        tests++;
        if ((last_accept - prev) % W != 0) begin
          fails++;
          $display("FAIL accept_interval: word %0d after %0d cycles required multiple of %0d",
                   i, last_accept - prev, W);
        end
      end
      prev = last_accept;
    end
    drain();
    tests++;
    if (last_run !== 120 || expq.size() != 0 || urun_cnt - u0 !== 0) begin
      fails++;
      $display("FAIL backpressure_stream: run=%0d pending=%0d underruns=%0d required 120, 0, 0",
               last_run, expq.size(), urun_cnt - u0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int base = bits_seen;
    int t    = 0;
    send_word(8'h12);
    send_word(8'h34);
    send_word(8'h56);
    while (bits_seen < base + 28 && t < 500) begin
      @(negedge clk);
      #1;
      t++;
    end
    #1 rst = 1'b1;
    #1;
    tests++;
    if ({dout, dout_valid, sync_active, frame_done, underrun, data_ready} !== 6'b100001) begin
      fails++;
      $display("FAIL midframe_reset: got %b required 100001",
               {dout, dout_valid, sync_active, frame_done, underrun, data_ready});
    end
    expq.delete();
    fpos    = 0;
    run_len = 0;
    gap_len = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    base   = bits_seen;
    det_sr = '0;
    flag_pos.delete();
    send_word(8'h9A);
    send_word(8'hBC);
    send_word(8'hDE);
    send_word(8'h3C);
    drain();
    tests++;
    if (last_run !== 40 || expq.size() != 0) begin
      fails++;
      $display("FAIL post_reset_frame: run=%0d pending=%0d required 40 and 0",
               last_run, expq.size());
    end
    tests++;
    if (flag_pos.size() != 2 || flag_pos[0] != base + 8 || flag_pos[1] != base + 40) begin
      fails++;
      $display("FAIL post_reset_flags: %0d detector flags, required 2 at bits 8 and 40",
               flag_pos.size());
    end
  endtask

  initial begin : main
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_underrun();
    test_backpressure();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
